spi_slave_regs: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 19 +
 rtl/spi_slave_sync.sv | 74 +++++++
 rtl/spi_slave_regs.sv | 259 +++++++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and FSM state encoding for the SPI register-access responder.
package spi_slave_pkg;

  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR,
    ST_RD,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Oversampling synchronizer and edge detector for the SPI pins (sys_clk domain).
// The csn chain resets low so a reset taken mid-transaction never produces a
// spurious csn fall; the FSM then sits in IDLE until the next genuine fall.
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic csn,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csn_fall,
  output logic csn_rise,
  output logic mosi_s
);

  // One extra stage beyond the synchronizer holds the previous synced value.
  localparam int unsigned CHAIN_W = SYNC_STAGES + 1;

  logic [CHAIN_W-1:0]     sclk_sh_q, sclk_sh_d;
  logic [CHAIN_W-1:0]     csn_sh_q, csn_sh_d;
  logic [SYNC_STAGES-1:0] mosi_sh_q, mosi_sh_d;
  logic sclk_rise_q, sclk_rise_d;
  logic sclk_fall_q, sclk_fall_d;
  logic csn_rise_q, csn_rise_d;
  logic csn_fall_q, csn_fall_d;
  logic mosi_s_q, mosi_s_d;

  // Shift chains and registered edge strobes aligned with the sampled mosi.
  always_comb begin
    sclk_sh_d   = {sclk_sh_q[CHAIN_W-2:0], sclk};
    csn_sh_d    = {csn_sh_q[CHAIN_W-2:0], csn};
    mosi_sh_d   = {mosi_sh_q[SYNC_STAGES-2:0], mosi};
    sclk_rise_d =  sclk_sh_q[SYNC_STAGES-1] & ~sclk_sh_q[SYNC_STAGES];
    sclk_fall_d = ~sclk_sh_q[SYNC_STAGES-1] &  sclk_sh_q[SYNC_STAGES];
    csn_rise_d  =  csn_sh_q[SYNC_STAGES-1]  & ~csn_sh_q[SYNC_STAGES];
    csn_fall_d  = ~csn_sh_q[SYNC_STAGES-1]  &  csn_sh_q[SYNC_STAGES];
    mosi_s_d    =  mosi_sh_q[SYNC_STAGES-1];
  end

  // Synchronizer and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sh_q   <= '0;
      csn_sh_q    <= '0;
      mosi_sh_q   <= '0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      csn_rise_q  <= 1'b0;
      csn_fall_q  <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      sclk_sh_q   <= sclk_sh_d;
      csn_sh_q    <= csn_sh_d;
      mosi_sh_q   <= mosi_sh_d;
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      csn_rise_q  <= csn_rise_d;
      csn_fall_q  <= csn_fall_d;
      mosi_s_q    <= mosi_s_d;
    end
  end

  assign sclk_rise = sclk_rise_q;
  assign sclk_fall = sclk_fall_q;
  assign csn_rise  = csn_rise_q;
  assign csn_fall  = csn_fall_q;
  assign mosi_s    = mosi_s_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder giving byte-wide register access in the sys_clk domain.
// Transaction: command byte, address byte, then data bytes with address
// auto-increment until csn rises. Optional build macro SPI_SLAVE_STATUS_EN adds
// command 0x05 returning {6'b0, err_sticky, wr_sticky}.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_sclk,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              err_cmd
);

  logic sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_s;

  spi_slave_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .sclk      (spi_sclk),
    .csn       (spi_csn),
    .mosi      (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .csn_fall  (csn_fall),
    .csn_rise  (csn_rise),
    .mosi_s    (mosi_s)
  );

  state_e                state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]            rx_sr_q, rx_sr_d;
  logic [7:0]            tx_sr_q, tx_sr_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  is_read_q, is_read_d;
  logic                  inc_pend_q, inc_pend_d;
  logic                  rd_cap_q, rd_cap_d;
`ifdef SPI_SLAVE_STATUS_EN
  logic                  stat_mode_q, stat_mode_d;
  logic                  stat_cap_q, stat_cap_d;
  logic                  err_sticky_q, err_sticky_d;
  logic                  wr_sticky_q, wr_sticky_d;
`endif

  logic [7:0] rx_byte;
  logic [7:0] tx_src;
  logic       byte_done;

  // Next-state, datapath and strobe logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    err_d      = 1'b0;
    is_read_d  = is_read_q;
    inc_pend_d = 1'b0;
    rd_cap_d   = re_q;
    rx_byte    = {rx_sr_q[6:0], mosi_s};
    byte_done  = sclk_rise && (bit_cnt_q == {BIT_CNT_W{1'b1}});
`ifdef SPI_SLAVE_STATUS_EN
    stat_mode_d  = stat_mode_q;
    stat_cap_d   = 1'b0;
    err_sticky_d = err_sticky_q | err_q;
    wr_sticky_d  = wr_sticky_q | we_q;
    // Fresh transmit byte: read data lands one cycle after reg_re.
    if (rd_cap_q) begin
      tx_src = reg_rdata;
    end else if (stat_cap_q) begin
      tx_src = {6'b0, err_sticky_q, wr_sticky_q};
    end else begin
      tx_src = tx_sr_q;
    end
`else
    tx_src = rd_cap_q ? reg_rdata : tx_sr_q;
`endif
    tx_sr_d = tx_src;

    // Deferred post-write address increment.
    if (inc_pend_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
        end
      end
      ST_CMD, ST_ADDR, ST_WR, ST_RD: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          rx_sr_d   = rx_byte;
        end
        if (byte_done) begin
          case (state_q)
            ST_CMD: begin
              if (rx_byte == CMD_WRITE) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
                stat_mode_d = 1'b0;
`endif
              end else if (rx_byte == CMD_READ) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
                stat_mode_d = 1'b0;
              end else if (rx_byte == CMD_STATUS) begin
                state_d     = ST_RD;
                stat_mode_d = 1'b1;
                stat_cap_d  = 1'b1;
`endif
              end else begin
                state_d = ST_IGNORE;
                err_d   = 1'b1;
              end
            end
            ST_ADDR: begin
              addr_d = rx_byte[ADDR_W-1:0];
              if (is_read_q) begin
                state_d = ST_RD;
                re_d    = 1'b1;
              end else begin
                state_d = ST_WR;
              end
            end
            ST_WR: begin
              wdata_d    = rx_byte;
              we_d       = 1'b1;
              inc_pend_d = 1'b1;
            end
            ST_RD: begin
`ifdef SPI_SLAVE_STATUS_EN
              if (stat_mode_q) begin
                stat_cap_d   = 1'b1;
                err_sticky_d = 1'b0;
                wr_sticky_d  = 1'b0;
              end else begin
                addr_d = addr_q + ADDR_W'(1);
                re_d   = 1'b1;
              end
`else
              addr_d = addr_q + ADDR_W'(1);
              re_d   = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase

    // Launch the next MISO bit on each sclk fall while reading.
    if ((state_q == ST_RD) && sclk_fall) begin
      miso_d  = tx_src[7];
      tx_sr_d = {tx_src[6:0], 1'b0};
    end

    // Deselect aborts from any state; a byte completing on the same cycle keeps its strobe.
    if (csn_rise && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end

    if (state_d != ST_RD) begin
      miso_d = 1'b0;
    end
    oe_d   = (state_d == ST_RD);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      is_read_q  <= 1'b0;
      inc_pend_q <= 1'b0;
      rd_cap_q   <= 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
      stat_mode_q  <= 1'b0;
      stat_cap_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      wr_sticky_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      is_read_q  <= is_read_d;
      inc_pend_q <= inc_pend_d;
      rd_cap_q   <= rd_cap_d;
`ifdef SPI_SLAVE_STATUS_EN
      stat_mode_q  <= stat_mode_d;
      stat_cap_q   <= stat_cap_d;
      err_sticky_q <= err_sticky_d;
      wr_sticky_q  <= wr_sticky_d;
`endif
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign busy        = busy_q;
  assign err_cmd     = err_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: SPI master model, register-file responder
// (rdata = addr + 0x40, one cycle after reg_re) and strobe monitor.
module tb_spi_slave_regs;

  localparam int HALF = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy, err_cmd;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] we_addr[$];
  logic [7:0] we_data[$];
  logic [7:0] re_addr[$];
  int         err_cnt = 0;
  bit         oe_seen = 0;
  bit         both_seen = 0;
  logic [7:0] rx;

  spi_slave_regs #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .spi_sclk    (spi_sclk),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .busy        (busy),
    .err_cmd     (err_cmd)
  );

  always #5 sys_clk = ~sys_clk;

  // Register-file responder: read data valid one cycle after reg_re.
  always @(posedge sys_clk) begin
    if (reg_re) reg_rdata <= reg_addr + 8'h40;
  end

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge sys_clk) begin
    if (reg_we) begin
      we_addr.push_back(reg_addr);
      we_data.push_back(reg_wdata);
    end
    if (reg_re) re_addr.push_back(reg_addr);
    if (err_cmd) err_cnt++;
    if (spi_miso_oe) oe_seen = 1;
    if (reg_we && reg_re) both_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    we_addr.delete();
    we_data.delete();
    re_addr.delete();
    err_cnt = 0;
    oe_seen = 0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Shift nbits of tx MSB first; miso captured at each rising sclk.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxo);
    rxo = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      wait_clk(HALF);
      spi_sclk = 1'b1;
      rxo = {rxo[6:0], spi_miso};
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic csn_low();
    spi_csn = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic csn_high();
    wait_clk(HALF);
    spi_csn = 1'b1;
    wait_clk(2 * HALF);
  endtask

  initial begin
    reg_rdata = '0;
    // Reset values
    wait_clk(4);
    sys_rst = 1'b0;
    wait_clk(1);
    check("reset_outputs", {spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, err_cmd}, 32'h0);
    wait_clk(2 * HALF);
    check("idle_busy", busy, 0);

    // Write burst 02,10,AA,55
    clear_mon();
    csn_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h10, 8, rx);
    check("wr_busy", busy, 1);
    spi_xfer(8'hAA, 8, rx);
    spi_xfer(8'h55, 8, rx);
    csn_high();
    check("wr_count", we_addr.size(), 2);
    check("wr0_addr", we_addr[0], 8'h10);
    check("wr0_data", we_data[0], 8'hAA);
    check("wr1_addr", we_addr[1], 8'h11);
    check("wr1_data", we_data[1], 8'h55);
    check("wr_addr_after", reg_addr, 8'h12);
    check("wr_oe", oe_seen, 0);
    check("wr_no_re", re_addr.size(), 0);
    check("wr_busy_end", busy, 0);

    // Read burst 03,FE + 3 bytes with wrap
    clear_mon();
    csn_low();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'hFE, 8, rx);
    check("rd_oe_on", spi_miso_oe, 1);
    spi_xfer(8'h00, 8, rx);
    check("rd_byte0", rx, 8'h3E);
    spi_xfer(8'h00, 8, rx);
    check("rd_byte1", rx, 8'h3F);
    spi_xfer(8'h00, 8, rx);
    check("rd_byte2", rx, 8'h40);
    csn_high();
    check("rd_re0", re_addr[0], 8'hFE);
    check("rd_re1", re_addr[1], 8'hFF);
    check("rd_re2_wrap", re_addr[2], 8'h00);
    check("rd_oe_off", spi_miso_oe, 0);
    check("rd_no_we", we_addr.size(), 0);

    // Abort mid-byte, then a clean write
    clear_mon();
    csn_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h20, 8, rx);
    spi_xfer(8'hC3, 5, rx);
    csn_high();
    check("abort_no_we", we_addr.size(), 0);
    csn_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h21, 8, rx);
    spi_xfer(8'h77, 8, rx);
    csn_high();
    check("abort_next_cnt", we_addr.size(), 1);
    check("abort_next_addr", we_addr[0], 8'h21);
    check("abort_next_data", we_data[0], 8'h77);

    // csn rises together with the last data rise: byte still written
    clear_mon();
    csn_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h60, 8, rx);
    spi_xfer(8'h5A, 7, rx);
    spi_mosi = 1'b0;
    wait_clk(HALF);
    spi_sclk = 1'b1;
    spi_csn  = 1'b1;
    wait_clk(HALF);
    spi_sclk = 1'b0;
    wait_clk(2 * HALF);
    check("race_cnt", we_addr.size(), 1);
    check("race_addr", we_addr[0], 8'h60);
    check("race_data", we_data[0], 8'h5A);
    check("race_busy", busy, 0);

    // Unknown command
    clear_mon();
    csn_low();
    spi_xfer(8'h9F, 8, rx);
    spi_xfer(8'h12, 8, rx);
    spi_xfer(8'h34, 8, rx);
    csn_high();
    check("unk_err", err_cnt, 1);
    check("unk_no_we", we_addr.size(), 0);
    check("unk_no_re", re_addr.size(), 0);
    check("unk_oe", oe_seen, 0);

    // Reset in the middle of the second data byte of a read
    clear_mon();
    csn_low();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h30, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("rst_rd_byte0", rx, 8'h70);
    spi_xfer(8'h00, 3, rx);
    sys_rst = 1'b1;
    wait_clk(1);
    sys_rst = 1'b0;
    check("rst_mid_outputs", {spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, err_cmd}, 32'h0);
    clear_mon();
    spi_xfer(8'hFF, 5, rx);
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h99, 8, rx);
    csn_high();
    check("rst_ignored_we", we_addr.size(), 0);
    check("rst_ignored_re", re_addr.size(), 0);
    check("rst_ignored_oe", oe_seen, 0);
    csn_low();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h50, 8, rx);
    spi_xfer(8'h00, 8, rx);
    csn_high();
    check("rst_next_rd", rx, 8'h90);
    check("rst_next_re", re_addr[0], 8'h50);

`ifdef SPI_SLAVE_STATUS_EN
    // Status read after an error and a write
    csn_low();
    spi_xfer(8'h9F, 8, rx);
    csn_high();
    csn_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h40, 8, rx);
    spi_xfer(8'h11, 8, rx);
    csn_high();
    clear_mon();
    csn_low();
    spi_xfer(8'h05, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("stat_byte0", rx, 8'h03);
    spi_xfer(8'h00, 8, rx);
    check("stat_byte1", rx, 8'h00);
    csn_high();
    check("stat_no_re", re_addr.size(), 0);
    check("stat_no_err", err_cnt, 0);
`else
    // 0x05 is unknown without the status feature
    clear_mon();
    csn_low();
    spi_xfer(8'h05, 8, rx);
    spi_xfer(8'h00, 8, rx);
    csn_high();
    check("stat_unk_err", err_cnt, 1);
    check("stat_unk_oe", oe_seen, 0);
    check("stat_unk_re", re_addr.size(), 0);
`endif

    check("we_re_exclusive", both_seen, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
